// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered mux/arbiter.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_CH     = 16;

  // Width needed to index 'value' items; usable in parameter defaults.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter_nx1.sv
// Combinational rotate-priority pick: first requester after ptr, wrapping modulo N.
module rr_arbiter_nx1
  import mux_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          grant_onehot,
  output logic [clog2(N)-1:0]   grant_idx,
  output logic                  any_grant
);

  localparam int SELW = clog2(N);

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tools infer a latch.
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    // ptr itself is searched last (k = N), so a lone requester at ptr still wins.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_idx         = SELW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
    any_grant = found;
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 valid/ready mux with a one-entry output register; fixed-select or round-robin.
// Optional burst lock is compiled in with `define MUX_ARB_LOCK_EN.
module mux_arb_nx1
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      S,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic                 lock
`endif
);

  logic [SELW-1:0]  ptr;
  logic             can_load;
  logic [N-1:0]     fixed_onehot;
  logic [N-1:0]     rr_req;
  logic [N-1:0]     rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [N-1:0]     take;
  logic [WIDTH-1:0] load_data;
  logic [SELW-1:0]  load_src;

  assign can_load = !out_valid || out_ready;

  // An out-of-range S shifts the bit off the top, leaving no channel selected.
  assign fixed_onehot = N'(1) << S;

`ifdef MUX_ARB_LOCK_EN
  logic [N-1:0] ptr_onehot;
  assign ptr_onehot = N'(1) << ptr;
  assign rr_req     = lock ? (in_valid & ptr_onehot) : in_valid;
`else
  assign rr_req = in_valid;
`endif

  rr_arbiter_nx1 #(.N(N)) u_arb (
    .req          (rr_req),
    .ptr          (ptr),
    .grant_onehot (rr_grant),
    .grant_idx    (rr_idx),
    .any_grant    (rr_any)
  );

  always_comb begin
    in_ready = '0;
    if (can_load) in_ready = (mode == MODE_RR) ? rr_grant : fixed_onehot;
  end

  assign take = in_valid & in_ready;

  // take is at most one-hot, so OR-ing the candidates is a plain mux.
  always_comb begin
    load_data = '0;
    load_src  = '0;
    for (int i = 0; i < N; i++) begin
      if (take[i]) begin
        load_data = load_data | in_data[i*WIDTH +: WIDTH];
        load_src  = SELW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data register is reset too, so out_data reads 0 after reset
      // rather than stale contents; this is a single register, not a memory.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= SELW'(N - 1);
    end else if (can_load) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_valid <= |take;
      if (|take) begin
        out_data <= load_data;
        out_src  <= load_src;
        if (mode == MODE_RR) ptr <= load_src;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Self-checking bench for mux_arb_nx1: directed scenarios plus random traffic vs a reference model.
module tb_mux_arb_nx1;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               mode;
  logic [SELW-1:0]    S;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_valid;
  logic               out_ready;
  bit                 lock_on = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Reference model state: pointer (last granted channel) and the held beat.
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;

  always #5 clk = ~clk;

`ifdef MUX_ARB_LOCK_EN
  logic lock;
  assign lock = lock_on;
`endif

  mux_arb_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .S         (S),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = N - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
  endtask

  // Which channel may hand over a beat this cycle, from the selection rules.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_valid && !out_ready) return r;
    if (mode == 1'b0) begin
      if (int'(S) < N) r[S] = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (in_valid[idx] && (!lock_on || idx == m_ptr)) begin
          r[idx] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // Inputs are set by the caller just after a falling edge; one full clock follows.
  task automatic tick(input string tag);
    logic [N-1:0] exp_r;
    int           t;
    #1;
    exp_r = model_ready();
    check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_r));
    t = -1;
    for (int i = 0; i < N; i++) if (in_valid[i] && exp_r[i]) t = i;
    @(posedge clk);
    if (!m_valid || out_ready) begin
      m_valid = (t >= 0);
      if (t >= 0) begin
        m_data = in_data[t*WIDTH +: WIDTH];
        m_src  = t;
        if (mode) m_ptr = t;
      end
    end
    #1;
    check({tag, "_out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, "_out_data"}, 64'(out_data), 64'(m_data));
      check({tag, "_out_src"},  64'(out_src),  64'(m_src));
    end
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    S         = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_src",   64'(out_src),   64'd0);
    reset = 1'b0;

    // Fixed select: channel i carries i+1.
    in_data  = {32'd3, 32'd2, 32'd1};
    in_valid = 3'b111;
    for (int s = 0; s < 3; s++) begin
      S = SELW'(s);
      tick("fix");
      check("fix_data", 64'(out_data), 64'(s + 1));
      check("fix_src",  64'(out_src),  64'(s));
    end
    in_valid = 3'b000;
    tick("fix_drain");

    // Out-of-range select: nothing is ever accepted.
    S        = 2'd3;
    in_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      tick("fix_s3");
      check("fix_s3_ready", 64'(in_ready), 64'd0);
      check("fix_s3_valid", 64'(out_valid), 64'd0);
    end

    // Round robin, all valid, free-flowing output: 0,1,2,0,1,2 with no bubble.
    mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick("rr_seq");
      check("rr_seq_src", 64'(out_src), 64'(c % 3));
    end

    // Stall after one beat; the held beat stays put and the pointer does not move.
    tick("rr_pre_stall");
    check("rr_pre_stall_src", 64'(out_src), 64'd0);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick("rr_stall");
      check("rr_stall_ready", 64'(in_ready), 64'd0);
      check("rr_stall_src",   64'(out_src),  64'd0);
      check("rr_stall_data",  64'(out_data), 64'd1);
    end
    out_ready = 1'b1;
    tick("rr_resume");
    check("rr_resume_src", 64'(out_src), 64'd1);

    // Lone requester at the pointer's own channel wraps back to itself.
    in_valid = 3'b100;
    tick("rr_ch2_a");
    check("rr_ch2_a_src", 64'(out_src), 64'd2);
    tick("rr_ch2_b");
    check("rr_ch2_b_src", 64'(out_src), 64'd2);
    in_valid = 3'b001;
    tick("rr_ch0");
    check("rr_ch0_src", 64'(out_src), 64'd0);

    // Asynchronous reset while a beat is held.
    in_valid = 3'b111;
    tick("pre_rst");
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data",  64'(out_data),  64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick("post_rst");
    check("post_rst_src", 64'(out_src), 64'd0);

`ifdef MUX_ARB_LOCK_EN
    tick("lock_first");
    check("lock_first_src", 64'(out_src), 64'd1);
    lock_on = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick("lock_burst");
      check("lock_burst_src", 64'(out_src), 64'd1);
    end
    lock_on = 1'b0;
`endif

    // Random traffic with mode/select/backpressure changing every cycle.
    for (int c = 0; c < 400; c++) begin
      mode      = 1'($urandom_range(0, 1));
      S         = SELW'($urandom_range(0, 3));
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
Parametrised N:1 data multiplexer with a registered output stage and valid/ready handshaking on every input and on the output.
- Generalises the fixed 3:1 32-bit combinational mux to N channels of WIDTH bits.
- Two run-time modes: fixed select (software/decoder-driven) and round-robin arbitration.
- Sits in front of shared datapath resources in the RISC-V core, e.g. the writeback port or the memory request port fed by several sources.

Parameters:
WIDTH, 32, data width per channel in bits
N, 3, number of input channels (2..16)
SELW, $clog2(N), width of select and source-ID fields (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = fixed select by S, 1 = round-robin
S  in  SELW  channel select; used only when mode = 0
in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  in  N  per-channel valid
in_ready  out  N  per-channel ready (combinational)
out_data  out  WIDTH  registered selected data
out_src  out  SELW  registered index of the channel that supplied out_data
out_valid  out  1  registered output valid
out_ready  in  1  downstream ready

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_src=0, RR pointer=N-1, so channel 0 has first priority.
- Output register is one entry. It can accept when empty or drained this cycle: can_load = !out_valid | out_ready.
- Transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. Data appears on out_data with out_valid=1 on the next cycle (latency 1).
- At most one in_ready bit is high per cycle. in_ready depends on mode, S, in_valid, the pointer and can_load; it never depends on in_data.
- Fixed mode (mode=0):
  - in_ready[S] = can_load; all other bits are 0.
  - in_ready[S] is asserted even if in_valid[S]=0 (ready does not wait for valid).
  - S >= N: all in_ready=0, no transfer, no error flag.
- Round-robin mode (mode=1):
  - Grant goes to the first valid channel searching ptr+1, ptr+2, ... with wrap-around modulo N.
  - in_ready[grant] = can_load. No in_valid high: all in_ready=0.
  - Pointer updates to the granted index only on an actual transfer. A stalled output does not advance the pointer.
- Output holding: while out_valid=1 and out_ready=0, out_data and out_src stay stable and no input is accepted.
- Simultaneous drain and load: the new beat replaces the old one in the same edge with no bubble, giving full throughput of 1 beat/cycle.
- Mode or S change while out_valid=1: the held beat is unaffected; the new selection applies to the next accept.
- Pointer is not reset on a mode change.
- Reset mid-operation: any held beat is discarded immediately, out_valid drops asynchronously, and the pointer returns to N-1.

Optional Feature:
MUX_ARB_LOCK_EN
- Defined: adds input port `lock` (1 bit).
  - While lock=1 after a transfer in round-robin mode, the grant stays on the last-granted channel (the pointer-owned channel) and other channels are masked. This supports multi-beat bursts.
  - lock has no effect in fixed mode.
  - lock=1 with the locked channel not valid: no grant, no pointer change.
- Undefined: no `lock` port; pure round-robin as above.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - MAX_CH=16
  - a clog2 helper function
- Sub-module rr_arbiter_nx1 (parameter N):
  - inputs: req[N], ptr[SELW]
  - outputs: grant_onehot[N], grant_idx[SELW], any_grant
  - purely combinational rotate-priority pick; the top level holds all registers.

Test Plan:
- Reset then fixed mode, WIDTH=32, N=3, S=0/1/2, in_data={3,2,1}, all valid, out_ready=1 -> out_data 1, 2, 3 one cycle after each accept; out_src matches S.
- Fixed mode S=3 with all channels valid -> in_ready=000 and out_valid stays 0 for 5 cycles.
- RR mode, all three valid continuously, out_ready=1 -> out_src sequence 0,1,2,0,1,2 on back-to-back cycles with no bubble.
- RR mode, out_ready=0 for 4 cycles after the first beat -> out_data and out_src held stable, in_ready=000; after release the next grant is channel 1, not 2.
- Only channel 2 valid in RR mode with pointer=2 -> grant wraps to 2; pointer stays 2; then channel 0 valid -> grant 0.
- Assert reset while out_valid=1 -> out_valid=0 immediately; the next RR grant with all channels valid is channel 0. With MUX_ARB_LOCK_EN: lock=1 after the channel-1 grant -> four consecutive beats from channel 1.
